// File: rtl/ixc_slice_pkg.sv
// rtl/ixc_slice_pkg.sv - shared types and helpers for the ixc valid/ready slices
package ixc_slice_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        HALF  = 2'b01,
        FULL  = 2'b10
    } state_t;

    localparam int OCC_W = 2;

    // Beat count held by the slice in each state; the unused encoding reads as empty.
    function automatic logic [OCC_W-1:0] occ_of(input state_t s);
        case (s)
            HALF:    occ_of = 2'd1;
            FULL:    occ_of = 2'd2;
            default: occ_of = 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/ixc_skid_reg_26_if.sv
// rtl/ixc_skid_reg_26_if.sv - valid/ready/data beat channel for the skid slice
interface ixc_skid_reg_26_if #(
    parameter int WIDTH = 26
);
    logic             valid;
    logic             ready;
    logic [WIDTH-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/ixc_xfer_cnt.sv
// rtl/ixc_xfer_cnt.sv - wrapping enable counter shared by the ixc slices
module ixc_xfer_cnt #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (en) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/ixc_skid_reg_26.sv
// rtl/ixc_skid_reg_26.sv - two-entry registered skid slice feeding the 26-bit assign template
module ixc_skid_reg_26
    import ixc_slice_pkg::*;
#(
    parameter int WIDTH = 26,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    ixc_skid_reg_26_if.slave     in_if,
    ixc_skid_reg_26_if.master    out_if,
    output logic [OCC_W-1:0]     occupancy,
    output logic [CNT_W-1:0]     xfer_count
);

    state_t           state;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] skid_q;
    logic             in_fire;
    logic             out_fire;

    // Handshake outputs decode the state register only, so no ready path crosses the slice.
    assign in_if.ready  = (state != FULL);
    assign out_if.valid = (state != EMPTY);
    assign out_if.data  = main_q;
    assign occupancy    = occ_of(state);

    assign in_fire  = in_if.valid & in_if.ready;
    assign out_fire = out_if.valid & out_if.ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= EMPTY;
            main_q <= '0;
            skid_q <= '0;
        end else if (flush) begin
            state <= EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (in_fire) begin
                        state  <= HALF;
                        main_q <= in_if.data;
                    end
                end
                HALF: begin
                    if (in_fire && out_fire) begin
                        main_q <= in_if.data;
                    end else if (in_fire) begin
                        state  <= FULL;
                        skid_q <= in_if.data;
                    end else if (out_fire) begin
                        state <= EMPTY;
                    end
                end
                FULL: begin
                    // Older skid beat moves up so ordering stays first-in first-out.
                    if (out_fire) begin
                        state  <= HALF;
                        main_q <= skid_q;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

    // Downstream consumption counts even during a flush.
    ixc_xfer_cnt #(.CNT_W(CNT_W)) u_xfer_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (out_fire),
        .count (xfer_count)
    );

endmodule

// File: tb/tb_ixc_skid_reg_26.sv
// tb/tb_ixc_skid_reg_26.sv - self-checking bench for ixc_skid_reg_26 against a queue model
module tb_ixc_skid_reg_26;

    localparam int W = 26;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;

    always #5 clk = ~clk;

    ixc_skid_reg_26_if #(.WIDTH(W)) in_if ();
    ixc_skid_reg_26_if #(.WIDTH(W)) out_if ();
    ixc_skid_reg_26_if #(.WIDTH(W)) in4_if ();
    ixc_skid_reg_26_if #(.WIDTH(W)) out4_if ();

    logic [1:0]  occ;
    logic [1:0]  occ4;
    logic [15:0] cnt;
    logic [3:0]  cnt4;

    // Narrow-counter copy sees identical traffic to exercise counter wrap.
    assign in4_if.valid  = in_if.valid;
    assign in4_if.data   = in_if.data;
    assign out4_if.ready = out_if.ready;

    ixc_skid_reg_26 #(.WIDTH(W), .CNT_W(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .in_if      (in_if),
        .out_if     (out_if),
        .occupancy  (occ),
        .xfer_count (cnt)
    );

    ixc_skid_reg_26 #(.WIDTH(W), .CNT_W(4)) dut4 (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .in_if      (in4_if),
        .out_if     (out4_if),
        .occupancy  (occ4),
        .xfer_count (cnt4)
    );

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [W-1:0] q[$];
    int unsigned mcount = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs();
        check("in_ready",    32'(in_if.ready),  32'(q.size() < 2));
        check("out_valid",   32'(out_if.valid), 32'(q.size() > 0));
        check("occupancy",   32'(occ),          32'(q.size()));
        check("occupancy4",  32'(occ4),         32'(q.size()));
        check("xfer_count",  32'(cnt),          mcount & 32'hFFFF);
        check("xfer_count4", 32'(cnt4),         mcount & 32'hF);
        if (q.size() > 0) check("out_data", 32'(out_if.data), 32'(q[0]));
    endtask

    // Called at a falling edge: drive, let one rising edge pass, update model, check.
    task automatic step(input logic v, input logic [W-1:0] d, input logic rdy, input logic fl);
        bit ifire;
        bit ofire;
        in_if.valid  = v;
        in_if.data   = d;
        out_if.ready = rdy;
        flush        = fl;
        @(posedge clk);
        ifire = v && (q.size() < 2);
        ofire = rdy && (q.size() > 0);
        if (ofire) begin
            void'(q.pop_front());
            mcount++;
        end
        if (fl) q.delete();
        else if (ifire) q.push_back(d);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_out_valid"}, 32'(out_if.valid), 32'd0);
        check({tag, "_in_ready"},  32'(in_if.ready),  32'd1);
        check({tag, "_out_data"},  32'(out_if.data),  32'd0);
        check({tag, "_occupancy"}, 32'(occ),          32'd0);
        check({tag, "_xfer"},      32'(cnt),          32'd0);
    endtask

    initial begin
        in_if.valid  = 1'b1;
        in_if.data   = 26'h3FFFFFF;
        out_if.ready = 1'b0;
        rst_n        = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        rst_n = 1'b1;

        // First accepted beat appears one cycle later.
        step(1'b1, 26'h0000AAA, 1'b0, 1'b0);
        step(1'b0, 26'h0, 1'b1, 1'b0);

        // Back-to-back streaming; 17 transfers so far exercises the 4-bit wrap.
        for (int i = 1; i <= 16; i++) begin
            step(1'b1, W'(i), 1'b1, 1'b0);
            check("stream_in_ready", 32'(in_if.ready), 32'd1);
        end
        step(1'b0, 26'h0, 1'b1, 1'b0);
        check("stream_count", 32'(cnt), 32'd17);
        check("wrap_count4", 32'(cnt4), 32'd1);

        // Backpressure fills the skid entry; head must stay stable.
        step(1'b1, 26'h1234567, 1'b0, 1'b0);
        step(1'b1, 26'h0ABCDEF, 1'b0, 1'b0);
        step(1'b1, 26'h3333333, 1'b0, 1'b0);
        check("skid_occ",   32'(occ),         32'd2);
        check("skid_ready", 32'(in_if.ready), 32'd0);
        check("skid_head",  32'(out_if.data), 32'h1234567);
        step(1'b0, 26'h0, 1'b1, 1'b0);
        step(1'b0, 26'h0, 1'b1, 1'b0);
        check("skid_second", 32'(out_if.valid), 32'd0);

        // Flush while full with a simultaneous push and pop.
        step(1'b1, 26'h1111111, 1'b0, 1'b0);
        step(1'b1, 26'h1111112, 1'b0, 1'b0);
        step(1'b1, 26'h2222222, 1'b1, 1'b1);
        check("flush_occ",   32'(occ),          32'd0);
        check("flush_valid", 32'(out_if.valid), 32'd0);
        check("flush_count", 32'(cnt),          32'd20);
        step(1'b0, 26'h0, 1'b1, 1'b0);

        // Randomised traffic with occasional flushes.
        for (int i = 0; i < 1500; i++) begin
            step(($urandom % 4) != 0, W'($urandom), ($urandom % 3) != 0, ($urandom % 32) == 0);
        end

        // Asynchronous reset while full, between clock edges.
        step(1'b1, 26'h0F0F0F0, 1'b0, 1'b0);
        step(1'b1, 26'h0E0E0E0, 1'b0, 1'b0);
        step(1'b0, 26'h0, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_values("async");
        q.delete();
        mcount = 0;
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, 26'h0, 1'b1, 1'b0);
        step(1'b0, 26'h0, 1'b1, 1'b0);
        step(1'b1, 26'h0123456, 1'b1, 1'b0);
        step(1'b0, 26'h0, 1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ixc_skid_reg_26.md
Name: ixc_skid_reg_26

Overview:
- Registered valid/ready slice (two-entry skid buffer) on a 26-bit bus.
- Sits directly upstream of the 26-bit assign template and drives its R input from out_data.
- Purpose: break combinational timing on both data and ready paths while sustaining one beat per cycle.
- Provides occupancy and a transfer counter for emulation debug probes.

Parameters:
- WIDTH, 26, data bus width; must match the downstream assign template width.
- CNT_W, 16, width of the out-transfer counter.

Ports:
- clk  input  1  sole clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous discard of all buffered beats.
- in_valid  input  1  upstream beat valid.
- in_ready  output  1  slice can accept; registered, no combinational path from out_ready.
- in_data  input  WIDTH  upstream beat payload.
- out_valid  output  1  registered; main entry holds a beat.
- out_ready  input  1  downstream accepts.
- out_data  output  WIDTH  registered main-entry payload; feeds the assign template R.
- occupancy  output  2  number of held beats: 0, 1 or 2.
- xfer_count  output  CNT_W  count of out transfers, wraps modulo 2^CNT_W.

Behaviour:
- Handshake definitions: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Reset (rst_n=0, asynchronous):
  - state=EMPTY; main, skid and xfer_count cleared to 0.
  - Outputs: out_valid=0, in_ready=1, out_data=0, occupancy=0, xfer_count=0.
- Derived outputs, all decoded from registers only:
  - in_ready = (state != FULL).
  - out_valid = (state != EMPTY).
  - occupancy = EMPTY:0, HALF:1, FULL:2.
- State machine (evaluated only when flush=0):
  - EMPTY: in_fire -> HALF, main<=in_data.
  - HALF, in_fire & out_fire -> HALF, main<=in_data.
  - HALF, in_fire & !out_fire -> FULL, skid<=in_data.
  - HALF, !in_fire & out_fire -> EMPTY.
  - HALF, neither -> hold.
  - FULL: in_fire is impossible since in_ready=0. out_fire -> HALF, main<=skid. Otherwise hold.
- Timing:
  - Latency: a beat accepted in cycle N is presented on out_data with out_valid=1 in cycle N+1 when the slice was EMPTY, or when HALF with simultaneous out_fire.
  - Throughput: one beat per cycle sustained with out_ready held at 1.
- Ordering: strict FIFO; the skid beat always leaves after the main beat.
- Stability: while out_valid=1 and out_ready=0, out_data and out_valid hold unchanged.
- flush=1:
  - Next state is EMPTY regardless of in/out activity.
  - An in_fire in the same cycle is discarded.
  - An out_fire in the same cycle still counts in xfer_count, because downstream consumed it.
  - main/skid contents are not cleared, but are not observable once out_valid=0.
- xfer_count increments by 1 on each out_fire and wraps from 2^CNT_W-1 to 0. It is unaffected by flush.
- Reset mid-transfer: all held beats are lost immediately and asynchronously. No partial state survives.
- X handling: in_data is sampled only on in_fire. X on in_data while in_valid=0 must not propagate to out_data.

Decomposition:
- Shared package ixc_slice_pkg holds:
  - state enum {EMPTY, HALF, FULL} encoded 2'b00/2'b01/2'b10;
  - localparam OCC_W=2.
- One natural sub-module: ixc_xfer_cnt, a parameterised wrapping CNT_W-bit counter with an enable input. It is reused by the sibling slices.
- The data path stays flat in ixc_skid_reg_26.

Test Plan:
- Reset: hold rst_n=0 with in_valid=1, in_data=26'h3FFFFFF -> out_valid=0, in_ready=1, out_data=0, occupancy=0, xfer_count=0. Release rst_n -> first in_fire appears as out_valid=1 one cycle later.
- Streaming: out_ready=1, push 0x0000001..0x0000010 back-to-back -> 16 beats out in order, one per cycle, first at +1 cycle; in_ready stays 1; xfer_count=16.
- Backpressure/skid:
  - With out_ready=0, push 0x1234567 then 0x0ABCDEF -> occupancy=2, in_ready=0, out_data=0x1234567 held stable.
  - Raise out_ready -> 0x1234567 then 0x0ABCDEF, then out_valid=0.
- Flush: occupancy=2, assert flush with in_valid=1, in_data=0x2222222 and out_ready=1 -> next cycle occupancy=0, out_valid=0, 0x2222222 never emitted, xfer_count +1.
- Counter wrap: CNT_W=4, perform 17 out transfers -> xfer_count reads 15 after the 15th transfer, 0 after the 16th, 1 after the 17th.
- Async reset mid-operation: deassert rst_n between clock edges while FULL -> outputs go to reset values immediately without a clock edge. After release, no stale beat appears.
